gps_demod_mc: RTL and testbench
===============================

# gps_demod_mc

Parametrised multi-tap GPS/Galileo correlator channel, the next generation of the per-channel demodulator. It mixes the 1-bit IF sample with a quadrature LO and a code replica, and integrates I/Q for NTAPS half-chip-spaced correlator taps. Integration runs over a programmable number of code epochs, and results are dumped to the embedded CPU over a serial shift path with a valid/ack handshake. The code chip comes from an external generator (C/A or E1B), with optional BOC(1,1) modulation.

## Interface
- NTAPS, 3, number of correlator taps (odd, 3..7); tap (NTAPS-1)/2 is prompt
- INTEG_BITS, 18, accumulator width per I or Q
- CODEBITS, 13, chip counter width
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sample  in  1  1-bit IF sample
- wr_en  in  1  register write strobe
- wr_addr  in  3  0 lo_rate, 1 cg_rate, 2 mode, 3 integ_epochs, 4 pause, 5 overrun clear
- wr_data  in  32  write data
- cg_resume  in  1  re-enable code NCO after pause
- code_rd  out  1  full-chip advance strobe to external code generator
- code_chip  in  1  current code chip, sampled when code_rd=1
- nchip  out  CODEBITS  current chip index
- epoch  out  1  one-cycle pulse at code wrap
- dump_valid  out  1  integration result loaded and unacknowledged
- dump_ack  in  1  CPU done reading
- shift  in  1  advance serial output
- sout  out  1  serial result bit, MSB first
- overrun  out  1  sticky: dump lost

## Operation
- Registers:
  - lo_rate and cg_rate are 32-bit; reset 0.
  - mode = {wr_data[13] boc_en, wr_data[12:0] code_last}; reset boc_en=0, code_last=1022.
  - integ_epochs = wr_data[3:0]; reset 0. The period is integ_epochs+1 epochs.
- Pause: a write to addr 4 clears cg_en. cg_en is set again when cg_resume=1. cg_en resets to 1.
- Code NCO: cg_phase += cg_rate while cg_en; cg_phase resets to 0.
  - The full-chip event is the carry out of bit 31.
  - The half-chip tick is the carry out of bit 30 plus the full-chip event.
- Full-chip event with cg_en:
  - code_rd=1 in the same cycle.
  - code_chip is latched into code_l.
  - nchip <= (nchip >= code_last) ? 0 : nchip+1.
- Taps:
  - tap[0] = code_l ^ (boc_en & cg_phase[31]).
  - On each half-chip tick, tap[k] <= tap[k-1] for k=1..NTAPS-1.
  - Taps hold while paused.
- LO: lo_phase += lo_rate, free-running.
  - LO_I = {1,1,0,0}[lo_phase[31:30]] and LO_Q = {0,1,1,0}[lo_phase[31:30]], indexed MSB-first.
- Mixers: d = sample ^ tap[k] ^ LO, registered.
- Accumulators: add +1 when d=0 and -1 when d=1, in two's complement, wrapping modulo 2^INTEG_BITS.
- Dump:
  - An epoch counter counts epoch pulses. On the pulse completing the period, the dump flag fires.
  - On the next cycle the serial register loads {I0,Q0,I1,Q1,…}. Each accumulator restarts from that cycle's mixer contribution alone, so no sample is lost or counted twice.
  - dump_valid is set.
- Handshake:
  - dump_ack clears dump_valid.
  - A load while dump_valid=1 and no ack in the same cycle sets overrun; the new data overwrites the old.
  - A load with simultaneous ack leaves dump_valid=1 and does not set overrun.
  - A write to addr 5 clears overrun.
- Serial path: shift moves the register left one bit; sout = MSB. A load takes priority over shift.

## Timing
- Reset values: code_rd=0, nchip=0, epoch=0, dump_valid=0, overrun=0, sout=0.
- Reset also clears the accumulators, the epoch counter, cg_phase, lo_phase and the taps.
- code_rd is combinational from the carry, gated by cg_en. nchip and code_l update on the same edge.
- epoch: registered, high in the cycle after nchip becomes 0.
- Dump load happens 1 cycle after the completing epoch pulse. dump_valid rises at that edge.
- Mixer to accumulator: 1 cycle of latency.
- code_last write below the current nchip: nchip wraps to 0 at the next chip.
- integ_epochs write: takes effect at the next period start. The current period completes with its old length.
- Reset mid-dump: the serial register contents are don't-care, but dump_valid=0.

## Structure
- Package gps_demod_pkg holds:
  - register address constants
  - mode field bit positions
  - LO sin/cos lookup constants
- Sub-module gps_corr_tap holds the mixer and the I/Q accumulator pair for one tap, instantiated NTAPS times by generate.
- The NCOs, chip counter, tap line, epoch/dump control and serial register sit in the top level.

## Test plan
- cg_rate=2^30 (4 cycles/chip), code_last=9, integ_epochs=0:
  - code_rd every 4 cycles.
  - epoch every 40 cycles.
  - dump_valid rises 1 cycle after each epoch.
- sample = constant code replica, lo_rate=0, NTAPS=3:
  - prompt I = ±40 per 1-epoch dump.
  - early and late magnitudes equal and smaller than prompt.
- integ_epochs=3: a dump every 4th epoch, and the accumulator total equals the sum of the samples over exactly 160 cycles.
- Never ack, 2 dumps: overrun=1 and the second result is shifted out. A write to addr 5 clears overrun.
- Ack coincident with load: dump_valid stays 1 and overrun stays 0.
- Pause mid-code at nchip=5, resume after 17 cycles: nchip resumes at 5, with no code_rd while paused.

Source files
------------

// File: rtl/gps_demod_pkg.sv
// gps_demod_pkg: register map, mode field positions and LO lookup for gps_demod_mc
package gps_demod_pkg;
  localparam logic [2:0] ADDR_LO_RATE = 3'd0;
  localparam logic [2:0] ADDR_CG_RATE = 3'd1;
  localparam logic [2:0] ADDR_MODE    = 3'd2;
  localparam logic [2:0] ADDR_INTEG   = 3'd3;
  localparam logic [2:0] ADDR_PAUSE   = 3'd4;
  localparam logic [2:0] ADDR_OVR_CLR = 3'd5;
  localparam int MODE_BOC     = 13;
  localparam int MODE_LAST_HI = 12;
  localparam int CODE_LAST_RST = 1022;
  localparam logic [3:0] LO_I_LUT = 4'b1100;
  localparam logic [3:0] LO_Q_LUT = 4'b0110;
  // LUTs are written MSB-first: phase 0 selects bit 3
  function automatic logic lo_bit(input logic [3:0] lut, input logic [1:0] ph);
    return lut[2'd3 - ph];
  endfunction
endpackage

// File: rtl/gps_corr_tap.sv
// gps_corr_tap: registered 1-bit I/Q mixer and wrapping +/-1 accumulator pair for one tap
module gps_corr_tap import gps_demod_pkg::*; #(
  parameter int INTEG_BITS = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample,
  input  logic                  tap,
  input  logic                  lo_i,
  input  logic                  lo_q,
  input  logic                  dump,
  output logic [INTEG_BITS-1:0] acc_i,
  output logic [INTEG_BITS-1:0] acc_q
);
  logic d_i, d_q;
  logic [INTEG_BITS-1:0] step_i, step_q;
  always_comb begin
    step_i = d_i ? '1 : INTEG_BITS'(1);
    step_q = d_q ? '1 : INTEG_BITS'(1);
  end
  // on dump the accumulator restarts with this cycle's contribution so none is lost
  always_ff @(posedge clk) begin
    if (rst) begin
      d_i   <= 1'b0;
      d_q   <= 1'b0;
      acc_i <= '0;
      acc_q <= '0;
    end else begin
      d_i   <= sample ^ tap ^ lo_i;
      d_q   <= sample ^ tap ^ lo_q;
      acc_i <= (dump ? '0 : acc_i) + step_i;
      acc_q <= (dump ? '0 : acc_q) + step_q;
    end
  end
endmodule

// File: rtl/gps_demod_mc.sv
// gps_demod_mc: multi-tap GPS/Galileo correlator channel with serial dump and valid/ack handshake
module gps_demod_mc import gps_demod_pkg::*; #(
  parameter int NTAPS      = 3,
  parameter int INTEG_BITS = 18,
  parameter int CODEBITS   = 13
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample,
  input  logic                wr_en,
  input  logic [2:0]          wr_addr,
  input  logic [31:0]         wr_data,
  input  logic                cg_resume,
  output logic                code_rd,
  input  logic                code_chip,
  output logic [CODEBITS-1:0] nchip,
  output logic                epoch,
  output logic                dump_valid,
  input  logic                dump_ack,
  input  logic                shift,
  output logic                sout,
  output logic                overrun
);
  localparam int SW = 2 * NTAPS * INTEG_BITS;
  logic [31:0] lo_rate, cg_rate, lo_phase, cg_phase;
  logic [32:0] cg_sum;
  logic boc_en, cg_en, code_l, c30, full, half, wrap, dump, lo_i, lo_q, tap0;
  logic [CODEBITS-1:0] code_last;
  logic [3:0] integ_epochs, per_len, ecnt;
  logic [NTAPS-2:0] line;
  logic [NTAPS-1:0] tap;
  logic [SW-1:0] sreg, word;
  always_comb begin
    cg_sum  = {1'b0, cg_phase} + {1'b0, cg_rate};
    c30     = cg_sum[31] ^ cg_phase[31] ^ cg_rate[31];
    full    = cg_sum[32];
    code_rd = cg_en & full;
    half    = cg_en & (c30 | full);
    wrap    = code_rd & (nchip >= code_last);
    dump    = epoch & (ecnt >= per_len);
    lo_i    = lo_bit(LO_I_LUT, lo_phase[31:30]);
    lo_q    = lo_bit(LO_Q_LUT, lo_phase[31:30]);
    tap0    = code_l ^ (boc_en & cg_phase[31]);
    tap     = {line, tap0};
    sout    = sreg[SW-1];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      lo_rate      <= '0;
      cg_rate      <= '0;
      boc_en       <= 1'b0;
      code_last    <= CODEBITS'(CODE_LAST_RST);
      integ_epochs <= '0;
      cg_en        <= 1'b1;
      lo_phase     <= '0;
      cg_phase     <= '0;
      code_l       <= 1'b0;
      nchip        <= '0;
      line         <= '0;
      epoch        <= 1'b0;
      ecnt         <= '0;
      per_len      <= '0;
      dump_valid   <= 1'b0;
      overrun      <= 1'b0;
      sreg         <= '0;
    end else begin
      if (wr_en && wr_addr == ADDR_LO_RATE) lo_rate <= wr_data;
      if (wr_en && wr_addr == ADDR_CG_RATE) cg_rate <= wr_data;
      if (wr_en && wr_addr == ADDR_MODE) begin
        boc_en    <= wr_data[MODE_BOC];
        code_last <= CODEBITS'(wr_data[MODE_LAST_HI:0]);
      end
      if (wr_en && wr_addr == ADDR_INTEG) integ_epochs <= wr_data[3:0];
      cg_en    <= cg_resume | (cg_en & !(wr_en && wr_addr == ADDR_PAUSE));
      lo_phase <= lo_phase + lo_rate;
      if (cg_en) cg_phase <= cg_sum[31:0];
      if (code_rd) begin
        code_l <= code_chip;
        nchip  <= wrap ? '0 : nchip + CODEBITS'(1);
      end
      if (half) line <= tap[NTAPS-2:0];
      epoch <= wrap;
      // period length is latched only at a period boundary
      if (epoch) ecnt <= dump ? '0 : ecnt + 4'd1;
      if (dump) per_len <= integ_epochs;
      dump_valid <= dump | (dump_valid & !dump_ack);
      overrun    <= (overrun & !(wr_en && wr_addr == ADDR_OVR_CLR)) | (dump & dump_valid & !dump_ack);
      sreg       <= dump ? word : shift ? {sreg[SW-2:0], 1'b0} : sreg;
    end
  end
  for (genvar k = 0; k < NTAPS; k++) begin : g_tap
    logic [INTEG_BITS-1:0] ai, aq;
    gps_corr_tap #(.INTEG_BITS(INTEG_BITS)) u_tap (
      .clk(clk), .rst(rst), .sample(sample), .tap(tap[k]), .lo_i(lo_i), .lo_q(lo_q),
      .dump(dump), .acc_i(ai), .acc_q(aq)
    );
    assign word[SW-1-2*k*INTEG_BITS -: 2*INTEG_BITS] = {ai, aq};
  end
endmodule

// File: tb/tb_gps_demod_mc.sv
// tb_gps_demod_mc: table-driven dump checks with an expected-result queue, plus timing corner cases
module tb_gps_demod_mc;
  import gps_demod_pkg::*;
  localparam int NT = 3, IB = 18, CB = 13, SW = 2 * NT * IB;
  logic clk = 1'b0, rst = 1'b1, sample = 1'b0, wr_en = 1'b0, cg_resume = 1'b0;
  logic code_chip = 1'b0, dump_ack = 1'b0, shift = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic code_rd, epoch, dump_valid, sout, overrun;
  logic [CB-1:0] nchip;
  int checks = 0, errors = 0;
  typedef struct packed {logic [3:0] integ; int ei, eq, pi, pq, li, lq;} vec_t;
  logic [SW-1:0] exp_q[$];
  logic [9:0] pat = 10'b1101000111;

  gps_demod_mc #(.NTAPS(NT), .INTEG_BITS(IB), .CODEBITS(CB)) dut (
    .clk(clk), .rst(rst), .sample(sample), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .cg_resume(cg_resume), .code_rd(code_rd), .code_chip(code_chip),
    .nchip(nchip), .epoch(epoch), .dump_valid(dump_valid), .dump_ack(dump_ack),
    .shift(shift), .sout(sout), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // external code generator; the IF sample is the chip stream delayed by half a chip (2 cycles)
  initial begin
    int g = 0;
    logic ml = 1'b0, d1 = 1'b0, rd;
    code_chip = pat[9];
    forever begin
      @(negedge clk);
      rd = code_rd;
      @(posedge clk);
      #1;
      sample = d1;
      d1 = ml;
      if (rd) begin
        ml = code_chip;
        g = (g == 9) ? 0 : g + 1;
        code_chip = pat[9-g];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic sig(input int w);
    return (w == 0) ? code_rd : (w == 1) ? epoch : dump_valid;
  endfunction

  task automatic wait_on(input int w, input string nm);
    for (int n = 0; n < 2000; n++) begin
      if (sig(w)) return;
      @(negedge clk);
    end
    chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    wr_addr = a;
    wr_data = d;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic ack();
    dump_ack = 1'b1;
    @(negedge clk);
    dump_ack = 1'b0;
  endtask

  function automatic logic [SW-1:0] mk(input int ei, eq, pi, pq, li, lq);
    return {IB'(ei), IB'(eq), IB'(pi), IB'(pq), IB'(li), IB'(lq)};
  endfunction

  // freeze the code NCO so no new dump lands while the result is shifted out
  task automatic read_dump(input string pre);
    logic [SW-1:0] v, e;
    v = '0;
    wr(ADDR_PAUSE, 32'd0);
    for (int i = 0; i < SW; i++) begin
      v[SW-1-i] = sout;
      shift = 1'b1;
      @(negedge clk);
    end
    shift = 1'b0;
    if (exp_q.size() == 0) chk({pre, "_queue_empty"}, 32'd0, 32'd1);
    else begin
      e = exp_q.pop_front();
      for (int f = 0; f < 2 * NT; f++)
        chk($sformatf("%s_field%0d", pre, f), 32'(v[SW-1-f*IB -: IB]), 32'(e[SW-1-f*IB -: IB]));
    end
    cg_resume = 1'b1;
    @(negedge clk);
    cg_resume = 1'b0;
  endtask

  initial begin
    vec_t tbl[3];
    int n;
    tbl[0] = '{4'd0, -24, 24, -40, 40, -24, 24};
    tbl[1] = '{4'd1, -48, 48, -80, 80, -48, 48};
    tbl[2] = '{4'd3, -96, 96, -160, 160, -96, 96};
    repeat (3) @(negedge clk);
    chk("rst_code_rd", 32'(code_rd), 32'd0);
    chk("rst_nchip", 32'(nchip), 32'd0);
    chk("rst_epoch", 32'(epoch), 32'd0);
    chk("rst_dump_valid", 32'(dump_valid), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_sout", 32'(sout), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    wr(ADDR_MODE, 32'd9);
    wr(ADDR_INTEG, 32'd0);
    wr(ADDR_LO_RATE, 32'd0);
    wr(ADDR_CG_RATE, 32'h4000_0000);
    // chip and epoch cadence
    dump_ack = 1'b1;
    wait_on(0, "rd");
    for (int k = 0; k < 2; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!code_rd && n < 100);
      chk("rd_gap", 32'(n), 32'd4);
    end
    wait_on(1, "epoch");
    n = 0;
    do begin @(negedge clk); n++; end while (!epoch && n < 200);
    chk("epoch_gap", 32'(n), 32'd40);
    chk("epoch_nchip", 32'(nchip), 32'd0);
    dump_ack = 1'b0;
    chk("dv_at_epoch", 32'(dump_valid), 32'd0);
    @(negedge clk);
    chk("dv_after_epoch", 32'(dump_valid), 32'd1);
    // integration lengths; the first dumps after a change or a pause are discarded
    for (int t = 0; t < 3; t++) begin
      wr(ADDR_INTEG, 32'(tbl[t].integ));
      exp_q.push_back(mk(tbl[t].ei, tbl[t].eq, tbl[t].pi, tbl[t].pq, tbl[t].li, tbl[t].lq));
      ack(); wait_on(2, "dv");
      ack(); wait_on(2, "dv");
      ack(); wait_on(2, "dv");
      read_dump($sformatf("integ%0d", tbl[t].integ));
      ack();
    end
    // overrun: second dump never acked
    wr(ADDR_INTEG, 32'd0);
    wait_on(2, "dv");
    wr(ADDR_OVR_CLR, 32'd0);
    chk("ovr_before", 32'(overrun), 32'd0);
    wait_on(1, "epoch");
    @(negedge clk);
    chk("ovr_set", 32'(overrun), 32'd1);
    exp_q.push_back(mk(-24, 24, -40, 40, -24, 24));
    read_dump("ovr");
    wr(ADDR_OVR_CLR, 32'd0);
    chk("ovr_cleared", 32'(overrun), 32'd0);
    // ack coincident with load
    wait_on(1, "epoch");
    dump_ack = 1'b1;
    @(negedge clk);
    dump_ack = 1'b0;
    chk("ackload_dv", 32'(dump_valid), 32'd1);
    chk("ackload_ovr", 32'(overrun), 32'd0);
    ack();
    // pause at chip 5
    n = 0;
    while (!(nchip == CB'(5) && !code_rd) && n < 500) begin @(negedge clk); n++; end
    wr(ADDR_PAUSE, 32'd0);
    n = 0;
    for (int k = 0; k < 17; k++) begin
      if (code_rd) n++;
      @(negedge clk);
    end
    chk("pause_rd", 32'(n), 32'd0);
    chk("pause_nchip", 32'(nchip), 32'd5);
    cg_resume = 1'b1;
    @(negedge clk);
    cg_resume = 1'b0;
    wait_on(0, "resume_rd");
    chk("resume_nchip", 32'(nchip), 32'd5);
    @(negedge clk);
    chk("resume_next", 32'(nchip), 32'd6);
    // code_last lowered below current chip
    n = 0;
    while (!(nchip == CB'(7) && !code_rd) && n < 500) begin @(negedge clk); n++; end
    wr(ADDR_MODE, 32'd3);
    wait_on(0, "last_rd");
    @(negedge clk);
    chk("last_wrap", 32'(nchip), 32'd0);
    // reset with a dump pending
    wait_on(2, "dv");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_dv", 32'(dump_valid), 32'd0);
    chk("rst_mid_nchip", 32'(nchip), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
